// File: rtl/aes_img_pkg.sv
// Shared definitions for the image encrypter/decrypter pair: FSM states,
// keystream LFSR constants and the byte rotation helpers.
package aes_img_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } img_state_t;

   // Feedback taps s[7], s[5], s[4], s[3]
   localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
   localparam int unsigned ROT_AMT       = 32'd3;
   localparam logic [7:0]  ZERO_KEY_SEED = 8'h01;

   function automatic logic [7:0] rotl(input logic [7:0] v, input int unsigned n);
      logic [15:0] d;
      d = {v, v} << (n % 32'd8);
      return d[15:8];
   endfunction

   function automatic logic [7:0] rotr(input logic [7:0] v, input int unsigned n);
      logic [15:0] d;
      d = {v, v} >> (n % 32'd8);
      return d[7:0];
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

   // An all-zero seed would lock the LFSR, so key 0 maps to a fixed seed
   function automatic logic [7:0] key_seed(input logic [7:0] k);
      return (k == 8'h00) ? ZERO_KEY_SEED : k;
   endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 8-bit Fibonacci keystream generator; load takes priority over step.
module keystream_lfsr
   import aes_img_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       step,
   output logic [7:0] state
);

   // Keystream state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ZERO_KEY_SEED;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end else begin
         state <= state;
      end
   end

endmodule

// File: rtl/image_encrypter.sv
// Streams plaintext bytes from a 1-cycle-latency RAM, XORs with an LFSR
// keystream, rotates left and writes the ciphertext at the same address.
module image_encrypter
   import aes_img_pkg::*;
#(
   parameter int IMG_BYTES = 19200,
   parameter int ADDR_W    = 15
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        key,
   input  logic              active,
   input  logic [7:0]        plain_data,
   output logic [ADDR_W-1:0] read_addr,
   output logic [ADDR_W-1:0] write_addr,
   output logic [7:0]        write_data,
   output logic              write_en,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

   img_state_t state, next_state;
   logic       lfsr_load;
   logic       lfsr_step;
   logic       last_byte;
   logic [7:0] seed;
   logic [7:0] ks;

   assign seed      = key_seed(key);
   assign last_byte = (read_addr == LAST_ADDR);

   keystream_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .seed  (seed),
      .step  (lfsr_step),
      .state (ks)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and keystream control
   always_comb begin
      next_state = state;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               next_state = FETCH;
               lfsr_load  = 1'b1;
            end else begin
               next_state = state;
            end
         end
         FETCH: begin
            if (active) begin
               next_state = WAIT;
            end else begin
               next_state = FETCH;
            end
         end
         WAIT: next_state = WRITE;
         WRITE: begin
            if (last_byte) begin
               next_state = DONE;
            end else begin
               next_state = FETCH;
               lfsr_step  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Address, ciphertext and status registers; the RAM byte is consumed at the edge ending WAIT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_addr  <= ADDR_ZERO;
         write_addr <= ADDR_ZERO;
         write_data <= 8'h00;
         write_en   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         write_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (lfsr_load) begin
                  read_addr <= ADDR_ZERO;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            WAIT: begin
               write_data <= rotl(plain_data ^ ks, ROT_AMT);
               write_addr <= read_addr;
               write_en   <= 1'b1;
            end
            WRITE: begin
               if (last_byte) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end else begin
                  read_addr <= read_addr + ADDR_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_encrypter.sv
// Bench for image_encrypter: a 64-byte instance for data/round-trip/reset
// checks and a 4-byte instance for pass timing and stall behaviour.
module tb_image_encrypter;

   localparam int AW = 15;

   typedef struct {
      int         addr;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [7:0] key;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;

   logic          big_start = 1'b0, big_active = 1'b1;
   logic [7:0]    big_key = 8'h00, big_plain = 8'h00;
   logic [AW-1:0] big_ra, big_wa;
   logic [7:0]    big_wd;
   logic          big_we, big_busy, big_done;

   logic          sml_start = 1'b0, sml_active = 1'b1;
   logic [7:0]    sml_key = 8'h00, sml_plain = 8'h00;
   logic [AW-1:0] sml_ra, sml_wa;
   logic [7:0]    sml_wd;
   logic          sml_we, sml_busy, sml_done;

   logic [7:0] big_mem [64];
   logic [7:0] big_cipher [64];
   logic [7:0] sml_mem [4];
   exp_t       q_big[$];
   exp_t       q_sml[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         sml_writes = 0;

   image_encrypter #(.IMG_BYTES(64), .ADDR_W(AW)) u_big (
      .clk(clk), .reset(reset), .start(big_start), .key(big_key), .active(big_active),
      .plain_data(big_plain), .read_addr(big_ra), .write_addr(big_wa), .write_data(big_wd),
      .write_en(big_we), .busy(big_busy), .done(big_done)
   );

   image_encrypter #(.IMG_BYTES(4), .ADDR_W(AW)) u_sml (
      .clk(clk), .reset(reset), .start(sml_start), .key(sml_key), .active(sml_active),
      .plain_data(sml_plain), .read_addr(sml_ra), .write_addr(sml_wa), .write_data(sml_wd),
      .write_en(sml_we), .busy(sml_busy), .done(sml_done)
   );

   always #5 clk = ~clk;

   // Cycle counter and 1-cycle-latency plaintext RAMs
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      big_plain <= big_mem[big_ra[5:0]];
      sml_plain <= sml_mem[sml_ra[1:0]];
   end

   function automatic logic [7:0] m_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [7:0] m_enc(input logic [7:0] p, input logic [7:0] s);
      logic [7:0] x;
      x = p ^ s;
      return {x[4:0], x[7:5]};
   endfunction

   function automatic logic [7:0] m_dec(input logic [7:0] c, input logic [7:0] s);
      logic [7:0] r;
      r = {c[2:0], c[7:3]};
      return r ^ s;
   endfunction

   function automatic logic [7:0] m_seed(input logic [7:0] k);
      return (k == 8'h00) ? 8'h01 : k;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_big(input logic [7:0] k);
      exp_t       e;
      logic [7:0] s;
      s = m_seed(k);
      for (int i = 0; i < 64; i++) begin
         e.addr = i;
         e.data = m_enc(big_mem[i], s);
         q_big.push_back(e);
         s = m_step(s);
      end
   endtask

   task automatic push_sml(input logic [7:0] k);
      exp_t       e;
      logic [7:0] s;
      s = m_seed(k);
      for (int i = 0; i < 4; i++) begin
         e.addr = i;
         e.data = m_enc(sml_mem[i], s);
         q_sml.push_back(e);
         s = m_step(s);
      end
   endtask

   // Returns at the falling edge inside the first FETCH cycle
   task automatic start_big(input logic [7:0] k);
      @(negedge clk);
      big_key   = k;
      big_start = 1'b1;
      @(negedge clk);
      big_start = 1'b0;
   endtask

   task automatic start_sml(input logic [7:0] k);
      @(negedge clk);
      sml_key   = k;
      sml_start = 1'b1;
      @(negedge clk);
      sml_start = 1'b0;
   endtask

   task automatic wait_big_done(input int budget);
      int n;
      n = 0;
      while (!big_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("big_done_timeout", big_done, 1);
   endtask

   task automatic wait_sml_done(input int budget, output int t);
      int n;
      n = 0;
      while (!sml_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      check("sml_done_timeout", sml_done, 1);
   endtask

   // Scoreboard monitor for the 64-byte instance
   initial begin
      exp_t e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (big_we) begin
            check("big_we_back_to_back", prev, 0);
            if (q_big.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL big_unexpected_write addr=%0d data=%0h", big_wa, big_wd);
            end else begin
               e = q_big.pop_front();
               check("big_write_addr", big_wa, e.addr);
               check("big_write_data", big_wd, e.data);
            end
            big_cipher[big_wa[5:0]] = big_wd;
         end
         prev = big_we;
      end
   end

   // Scoreboard monitor for the 4-byte instance
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sml_we) begin
            sml_writes++;
            if (q_sml.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sml_unexpected_write addr=%0d data=%0h", sml_wa, sml_wd);
            end else begin
               e = q_sml.pop_front();
               check("sml_write_addr", sml_wa, e.addr);
               check("sml_write_data", sml_wd, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [4];
      int   t0, t1, n;
      logic [7:0] k, s;

      vecs[0] = '{key: 8'h00, p0: 8'h00, p1: 8'h00, e0: 8'h08, e1: 8'h10};
      vecs[1] = '{key: 8'hFF, p0: 8'h00, p1: 8'hFE, e0: 8'hFF, e1: 8'h00};
      vecs[2] = '{key: 8'h01, p0: 8'h01, p1: 8'h02, e0: 8'h00, e1: 8'h00};
      vecs[3] = '{key: 8'h80, p0: 8'h00, p1: 8'h00, e0: 8'h04, e1: 8'h08};

      for (int i = 0; i < 64; i++) big_mem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) sml_mem[i] = 8'($urandom);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_read_addr", big_ra, 0);
      check("rst_write_addr", big_wa, 0);
      check("rst_write_data", big_wd, 0);
      check("rst_write_en", big_we, 0);
      check("rst_busy", big_busy, 0);
      check("rst_done", big_done, 0);
      reset = 1'b1;

      // Table-driven first-bytes vectors
      for (int v = 0; v < 4; v++) begin
         big_mem[0] = vecs[v].p0;
         big_mem[1] = vecs[v].p1;
         push_big(vecs[v].key);
         start_big(vecs[v].key);
         check("vec_busy_after_start", big_busy, 1);
         check("vec_done_cleared", big_done, 0);
         wait_big_done(400);
         check("vec_byte0", big_cipher[0], vecs[v].e0);
         check("vec_byte1", big_cipher[1], vecs[v].e1);
      end

      // 4-byte pass timing without stalls: done on the 13th cycle counting the first FETCH as 1
      sml_writes = 0;
      push_sml(8'h3C);
      start_sml(8'h3C);
      t0 = cyc;
      wait_sml_done(100, t1);
      check("sml_pass_cycles", t1 - t0, 12);
      check("sml_busy_low_with_done", sml_busy, 0);
      check("sml_write_count", sml_writes, 4);
      start_sml(8'h3C);
      check("sml_start_clears_done", sml_done, 0);
      push_sml(8'h3C);
      wait_sml_done(100, t1);

      // Stall of 5 cycles in FETCH of byte 2
      for (int i = 0; i < 4; i++) sml_mem[i] = 8'($urandom);
      sml_writes = 0;
      push_sml(8'hA7);
      start_sml(8'hA7);
      t0 = cyc;
      n = 0;
      while (!(sml_we && sml_wa == 1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("stall_reached_byte1_write", sml_we, 1);
      sml_active = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_read_addr_held", sml_ra, 2);
         check("stall_no_write", sml_we, 0);
      end
      @(negedge clk);
      sml_active = 1'b1;
      wait_sml_done(100, t1);
      check("stall_pass_cycles", t1 - t0, 17);
      check("stall_write_count", sml_writes, 4);

      // Round trip with random key; a second start mid-pass must be ignored
      for (int i = 0; i < 64; i++) big_mem[i] = 8'($urandom);
      k = 8'($urandom);
      push_big(k);
      start_big(k);
      repeat (20) @(negedge clk);
      big_key   = k ^ 8'h55;
      big_start = 1'b1;
      @(negedge clk);
      big_start = 1'b0;
      check("ignored_start_busy", big_busy, 1);
      check("ignored_start_done", big_done, 0);
      wait_big_done(400);
      s = m_seed(k);
      for (int i = 0; i < 64; i++) begin
         check("roundtrip_byte", m_dec(big_cipher[i], s), big_mem[i]);
         s = m_step(s);
      end

      // Asynchronous reset during WAIT of byte 7
      push_big(8'h5A);
      start_big(8'h5A);
      n = 0;
      while (!(big_we && big_wa == 6) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reset_reached_byte6_write", big_we, 1);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("arst_read_addr", big_ra, 0);
      check("arst_write_addr", big_wa, 0);
      check("arst_write_data", big_wd, 0);
      check("arst_write_en", big_we, 0);
      check("arst_busy", big_busy, 0);
      check("arst_done", big_done, 0);
      q_big.delete();
      @(negedge clk);
      reset = 1'b1;
      big_mem[0] = 8'h00;
      push_big(8'h00);
      start_big(8'h00);
      check("restart_read_addr", big_ra, 0);
      wait_big_done(400);
      check("restart_byte0_fresh_seed", big_cipher[0], 8'h08);

      repeat (3) @(negedge clk);
      check("big_queue_drained", q_big.size(), 0);
      check("sml_queue_drained", q_sml.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
